// File: rtl/pipeline_ctrl_pkg.sv
// Shared decode constants, PC-mux encodings and FSM states for the IF/EX/WB sequencing controller.
// ROM index bounds must track the control_decode ROM layout.
package pipeline_ctrl_pkg;

  localparam int CNT_W = 32;

  localparam logic [5:0] IDX_LOAD_LO    = 6'd10;
  localparam logic [5:0] IDX_LOAD_HI    = 6'd14;
  localparam logic [5:0] IDX_STORE_LO   = 6'd24;
  localparam logic [5:0] IDX_STORE_HI   = 6'd26;
  localparam logic [5:0] IDX_BR_LO      = 6'd27;
  localparam logic [5:0] IDX_BR_HI      = 6'd32;
  localparam logic [5:0] IDX_JAL        = 6'd35;
  localparam logic [5:0] IDX_JALR       = 6'd36;
  localparam logic [5:0] IDX_LAST_LEGAL = 6'd36;

  typedef logic [1:0] pc_sel_t;

  localparam pc_sel_t PC_SEL_SEQ  = 2'd0;
  localparam pc_sel_t PC_SEL_TGT  = 2'd1;
  localparam pc_sel_t PC_SEL_RST  = 2'd2;
  localparam pc_sel_t PC_SEL_HOLD = 2'd3;

  typedef enum logic [1:0] {
    ST_BOOT  = 2'd0,
    ST_RUN   = 2'd1,
    ST_MEM   = 2'd2,
    ST_FLUSH = 2'd3
  } state_t;

  typedef enum logic [2:0] {
    CLS_OTHER,
    CLS_LOAD,
    CLS_STORE,
    CLS_BRANCH,
    CLS_JUMP,
    CLS_ILLEGAL
  } idx_class_t;

  function automatic idx_class_t classify(input logic [5:0] idx);
    idx_class_t cls;
    cls = CLS_OTHER;
    if (idx > IDX_LAST_LEGAL)
      cls = CLS_ILLEGAL;
    else if (idx >= IDX_LOAD_LO && idx <= IDX_LOAD_HI)
      cls = CLS_LOAD;
    else if (idx >= IDX_STORE_LO && idx <= IDX_STORE_HI)
      cls = CLS_STORE;
    else if (idx >= IDX_BR_LO && idx <= IDX_BR_HI)
      cls = CLS_BRANCH;
    else if (idx == IDX_JAL || idx == IDX_JALR)
      cls = CLS_JUMP;
    return cls;
  endfunction

endpackage

// File: rtl/pipeline_ctrl_if.sv
// Pipeline-control bus between the sequencing controller (master) and the core datapath (slave).
interface pipeline_ctrl_if;
  import pipeline_ctrl_pkg::*;

  logic                ex_valid;
  logic [5:0]          ex_idx;
  logic [4:0]          ex_rd;
  logic                br_taken;
  logic                id_valid;
  logic [4:0]          id_rs1;
  logic [4:0]          id_rs2;
  logic                dmem_ready;
  logic                cnt_clr;

  pc_sel_t             pc_sel;
  logic                if_en;
  logic                id_kill;
  logic                ex_hold;
  logic                dmem_req;
  logic                retire;
  logic                illegal;
  logic                mem_err;
  logic [CNT_W-1:0]    cycle_cnt;
  logic [CNT_W-1:0]    instret_cnt;

  modport master (
    input  ex_valid, ex_idx, ex_rd, br_taken, id_valid, id_rs1, id_rs2, dmem_ready, cnt_clr,
    output pc_sel, if_en, id_kill, ex_hold, dmem_req, retire, illegal, mem_err,
           cycle_cnt, instret_cnt
  );

  modport slave (
    output ex_valid, ex_idx, ex_rd, br_taken, id_valid, id_rs1, id_rs2, dmem_ready, cnt_clr,
    input  pc_sel, if_en, id_kill, ex_hold, dmem_req, retire, illegal, mem_err,
           cycle_cnt, instret_cnt
  );

endinterface

// File: rtl/pipeline_ctrl_perf_counters.sv
// Cycle and retired-instruction counters, wrapping modulo 2^32.
// A synchronous clear takes precedence over a same-cycle increment.
import pipeline_ctrl_pkg::*;

module perf_counters (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             cycle_inc,
  input  logic             instret_inc,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] instret_cnt
);

  logic [CNT_W-1:0] cycle_q;
  logic [CNT_W-1:0] instret_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cycle_q   <= '0;
      instret_q <= '0;
    end else if (clr) begin
      cycle_q   <= '0;
      instret_q <= '0;
    end else begin
      if (cycle_inc)
        cycle_q <= cycle_q + CNT_W'(1);
      if (instret_inc)
        instret_q <= instret_q + CNT_W'(1);
    end
  end

  assign cycle_cnt   = cycle_q;
  assign instret_cnt = instret_q;

endmodule

// File: rtl/pipeline_ctrl.sv
// Sequencing controller for the IF/EX/WB core: boot, memory wait states, redirect flush, load-use stall.
// Control outputs are Mealy (state + current inputs); counters and sticky error flags are registered.
import pipeline_ctrl_pkg::*;

module pipeline_ctrl #(
  parameter int BOOT_CYCLES = 2,
  parameter int MEM_TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  pipeline_ctrl_if.master   bus
);

  localparam int BW = (BOOT_CYCLES > 1) ? $clog2(BOOT_CYCLES) : 1;
  localparam int WW = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT + 1) : 1;

  state_t      state;
  state_t      state_nxt;
  logic [BW-1:0] boot_cnt;
  logic [WW-1:0] wait_cnt;
  logic        boot_last;
  logic        wait_last;
  logic        illegal_q;
  logic        mem_err_q;

  idx_class_t  cls;
  logic        load_use;
  pc_sel_t     pc_sel;
  logic        if_en;
  logic        id_kill;
  logic        ex_hold;
  logic        dmem_req;
  logic        retire;
  logic        instret_inc;
  logic        set_illegal;
  logic        set_mem_err;

  assign boot_last = (boot_cnt == BW'(BOOT_CYCLES - 1));
  assign wait_last = (wait_cnt == WW'(MEM_TIMEOUT - 1));

  always_comb begin
    cls         = classify(bus.ex_idx);
    load_use    = bus.id_valid && (bus.ex_rd != 5'd0) &&
                  ((bus.ex_rd == bus.id_rs1) || (bus.ex_rd == bus.id_rs2));
    state_nxt   = state;
    pc_sel      = PC_SEL_SEQ;
    if_en       = 1'b1;
    id_kill     = 1'b0;
    ex_hold     = 1'b0;
    dmem_req    = 1'b0;
    retire      = 1'b0;
    instret_inc = 1'b0;
    set_illegal = 1'b0;
    set_mem_err = 1'b0;

    unique case (state)
      ST_BOOT: begin
        pc_sel  = PC_SEL_RST;
        id_kill = 1'b1;
        if (boot_last)
          state_nxt = ST_RUN;
      end

      ST_RUN: begin
        if (bus.ex_valid) begin
          unique case (cls)
            CLS_LOAD, CLS_STORE: begin
              dmem_req = 1'b1;
              if (bus.dmem_ready) begin
                retire      = 1'b1;
                instret_inc = 1'b1;
                if (cls == CLS_LOAD && load_use) begin
                  pc_sel  = PC_SEL_HOLD;
                  if_en   = 1'b0;
                  id_kill = 1'b1;
                end
              end else begin
                pc_sel    = PC_SEL_HOLD;
                if_en     = 1'b0;
                ex_hold   = 1'b1;
                state_nxt = ST_MEM;
              end
            end
            CLS_BRANCH, CLS_JUMP: begin
              retire      = 1'b1;
              instret_inc = 1'b1;
              if (cls == CLS_JUMP || bus.br_taken) begin
                pc_sel    = PC_SEL_TGT;
                id_kill   = 1'b1;
                state_nxt = ST_FLUSH;
              end
            end
            CLS_ILLEGAL: begin
              // Executes as a NOP: leaves the pipe but is not counted as retired work.
              retire      = 1'b1;
              set_illegal = 1'b1;
            end
            default: begin
              retire      = 1'b1;
              instret_inc = 1'b1;
            end
          endcase
        end
      end

      ST_MEM: begin
        dmem_req = 1'b1;
        if (bus.dmem_ready) begin
          retire      = 1'b1;
          instret_inc = 1'b1;
          state_nxt   = ST_RUN;
          if (cls == CLS_LOAD && load_use) begin
            pc_sel  = PC_SEL_HOLD;
            if_en   = 1'b0;
            id_kill = 1'b1;
          end
        end else if (wait_last) begin
          // Abandon the access so the core keeps moving; mem_err records the loss.
          retire      = 1'b1;
          set_mem_err = 1'b1;
          state_nxt   = ST_RUN;
        end else begin
          pc_sel  = PC_SEL_HOLD;
          if_en   = 1'b0;
          ex_hold = 1'b1;
        end
      end

      ST_FLUSH: begin
        id_kill   = 1'b1;
        state_nxt = ST_RUN;
      end

      default: state_nxt = ST_BOOT;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_BOOT;
      boot_cnt  <= '0;
      wait_cnt  <= '0;
      illegal_q <= 1'b0;
      mem_err_q <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == ST_BOOT && !boot_last)
        boot_cnt <= boot_cnt + BW'(1);
      wait_cnt <= (state == ST_MEM) ? wait_cnt + WW'(1) : '0;
      if (set_illegal)
        illegal_q <= 1'b1;
      if (set_mem_err)
        mem_err_q <= 1'b1;
    end
  end

  perf_counters u_perf (
    .clk         (clk),
    .rst         (rst),
    .clr         (bus.cnt_clr),
    .cycle_inc   (state != ST_BOOT),
    .instret_inc (instret_inc),
    .cycle_cnt   (bus.cycle_cnt),
    .instret_cnt (bus.instret_cnt)
  );

  assign bus.pc_sel   = pc_sel;
  assign bus.if_en    = if_en;
  assign bus.id_kill  = id_kill;
  assign bus.ex_hold  = ex_hold;
  assign bus.dmem_req = dmem_req;
  assign bus.retire   = retire;
  assign bus.illegal  = illegal_q;
  assign bus.mem_err  = mem_err_q;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed-vector bench for pipeline_ctrl: inputs change on the falling edge, outputs sampled 1 time unit later.
module tb_pipeline_ctrl;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_bad;
  int   n_wait;
  logic seen;

  pipeline_ctrl_if bus ();

  pipeline_ctrl #(
    .BOOT_CYCLES (2),
    .MEM_TIMEOUT (255)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [5:0] idx, input logic [4:0] rd,
                       input logic br, input logic idv, input logic [4:0] rs1,
                       input logic [4:0] rs2, input logic rdy, input logic clr);
    @(negedge clk);
    bus.ex_valid   = v;
    bus.ex_idx     = idx;
    bus.ex_rd      = rd;
    bus.br_taken   = br;
    bus.id_valid   = idv;
    bus.id_rs1     = rs1;
    bus.id_rs2     = rs2;
    bus.dmem_ready = rdy;
    bus.cnt_clr    = clr;
    #1;
  endtask

  task automatic bubble();
    drive(1'b0, 6'd0, 5'd0, 1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0);
  endtask

  task automatic clear();
    drive(1'b0, 6'd0, 5'd0, 1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 1'b1);
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    rst   = 1'b1;
    bus.ex_valid = 1'b0; bus.ex_idx = '0; bus.ex_rd = '0; bus.br_taken = 1'b0;
    bus.id_valid = 1'b0; bus.id_rs1 = '0; bus.id_rs2 = '0; bus.dmem_ready = 1'b0;
    bus.cnt_clr  = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    #1;
    chk("rst_pc_sel",   32'(bus.pc_sel), 32'd2);
    chk("rst_if_en",    32'(bus.if_en), 32'd1);
    chk("rst_id_kill",  32'(bus.id_kill), 32'd1);
    chk("rst_ex_hold",  32'(bus.ex_hold), 32'd0);
    chk("rst_dmem_req", 32'(bus.dmem_req), 32'd0);
    chk("rst_retire",   32'(bus.retire), 32'd0);
    chk("rst_cycle",    bus.cycle_cnt, 32'd0);
    chk("rst_instret",  bus.instret_cnt, 32'd0);
    chk("rst_illegal",  32'(bus.illegal), 32'd0);
    chk("rst_mem_err",  32'(bus.mem_err), 32'd0);

    // Boot: two cycles of reset vector with EX bubbles
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("boot1_pc_sel",  32'(bus.pc_sel), 32'd2);
    chk("boot1_id_kill", 32'(bus.id_kill), 32'd1);
    bubble();
    chk("boot2_pc_sel",  32'(bus.pc_sel), 32'd2);
    chk("boot2_id_kill", 32'(bus.id_kill), 32'd1);
    bubble();
    chk("run_pc_sel",  32'(bus.pc_sel), 32'd0);
    chk("run_id_kill", 32'(bus.id_kill), 32'd0);
    chk("run_cycle0",  bus.cycle_cnt, 32'd0);
    bubble();
    chk("run_cycle1",  bus.cycle_cnt, 32'd1);

    // lw with three not-ready cycles, ready on the fourth
    clear();
    drive(1'b1, 6'd12, 5'd5, 1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0);
    chk("lw_w1_req",    32'(bus.dmem_req), 32'd1);
    chk("lw_w1_hold",   32'(bus.ex_hold), 32'd1);
    chk("lw_w1_if_en",  32'(bus.if_en), 32'd0);
    chk("lw_w1_pc_sel", 32'(bus.pc_sel), 32'd3);
    chk("lw_w1_retire", 32'(bus.retire), 32'd0);
    drive(1'b1, 6'd12, 5'd5, 1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0);
    chk("lw_w2_hold",   32'(bus.ex_hold), 32'd1);
    chk("lw_w2_if_en",  32'(bus.if_en), 32'd0);
    drive(1'b1, 6'd12, 5'd5, 1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0);
    chk("lw_w3_hold",   32'(bus.ex_hold), 32'd1);
    chk("lw_w3_if_en",  32'(bus.if_en), 32'd0);
    chk("lw_w3_retire", 32'(bus.retire), 32'd0);
    drive(1'b1, 6'd12, 5'd5, 1'b0, 1'b0, 5'd0, 5'd0, 1'b1, 1'b0);
    chk("lw_rdy_retire", 32'(bus.retire), 32'd1);
    bubble();
    chk("lw_instret",  bus.instret_cnt, 32'd1);
    chk("lw_cycle",    bus.cycle_cnt, 32'd4);
    chk("bub_retire",  32'(bus.retire), 32'd0);

    // Load-use with immediate ready: one stall cycle, then fetch resumes
    drive(1'b1, 6'd12, 5'd5, 1'b0, 1'b1, 5'd0, 5'd5, 1'b1, 1'b0);
    chk("lu_retire",  32'(bus.retire), 32'd1);
    chk("lu_if_en",   32'(bus.if_en), 32'd0);
    chk("lu_id_kill", 32'(bus.id_kill), 32'd1);
    chk("lu_pc_sel",  32'(bus.pc_sel), 32'd3);
    drive(1'b0, 6'd0, 5'd0, 1'b0, 1'b1, 5'd0, 5'd5, 1'b0, 1'b0);
    chk("lu_next_if_en",   32'(bus.if_en), 32'd1);
    chk("lu_next_id_kill", 32'(bus.id_kill), 32'd0);
    drive(1'b1, 6'd12, 5'd5, 1'b0, 1'b1, 5'd6, 5'd7, 1'b1, 1'b0);
    chk("nolu_if_en",   32'(bus.if_en), 32'd1);
    chk("nolu_id_kill", 32'(bus.id_kill), 32'd0);
    drive(1'b1, 6'd12, 5'd0, 1'b0, 1'b1, 5'd0, 5'd0, 1'b1, 1'b0);
    chk("x0_if_en", 32'(bus.if_en), 32'd1);
    drive(1'b1, 6'd25, 5'd5, 1'b0, 1'b1, 5'd5, 5'd0, 1'b1, 1'b0);
    chk("sw_nolu_if_en", 32'(bus.if_en), 32'd1);

    // Taken branch: redirect + flush, then RUN
    drive(1'b1, 6'd27, 5'd0, 1'b1, 1'b1, 5'd0, 5'd0, 1'b0, 1'b0);
    chk("br_pc_sel",  32'(bus.pc_sel), 32'd1);
    chk("br_id_kill", 32'(bus.id_kill), 32'd1);
    chk("br_retire",  32'(bus.retire), 32'd1);
    bubble();
    chk("fl_id_kill", 32'(bus.id_kill), 32'd1);
    chk("fl_pc_sel",  32'(bus.pc_sel), 32'd0);
    chk("fl_if_en",   32'(bus.if_en), 32'd1);
    chk("fl_retire",  32'(bus.retire), 32'd0);
    bubble();
    chk("post_fl_kill", 32'(bus.id_kill), 32'd0);
    drive(1'b1, 6'd27, 5'd0, 1'b0, 1'b1, 5'd0, 5'd0, 1'b0, 1'b0);
    chk("nt_pc_sel",  32'(bus.pc_sel), 32'd0);
    chk("nt_id_kill", 32'(bus.id_kill), 32'd0);
    chk("nt_retire",  32'(bus.retire), 32'd1);
    drive(1'b1, 6'd35, 5'd1, 1'b0, 1'b1, 5'd0, 5'd0, 1'b0, 1'b0);
    chk("jal_pc_sel", 32'(bus.pc_sel), 32'd1);
    bubble();
    chk("jal_fl_kill", 32'(bus.id_kill), 32'd1);

    // Illegal index: NOP retire, sticky flag, not counted
    clear();
    drive(1'b1, 6'd40, 5'd0, 1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0);
    chk("ill_retire", 32'(bus.retire), 32'd1);
    chk("ill_pre",    32'(bus.illegal), 32'd0);
    bubble();
    chk("ill_set",     32'(bus.illegal), 32'd1);
    chk("ill_instret", bus.instret_cnt, 32'd0);
    bubble();
    chk("ill_sticky",  32'(bus.illegal), 32'd1);

    // Store that never completes: abandoned after 255 MEM cycles
    drive(1'b1, 6'd25, 5'd0, 1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0);
    chk("to_req", 32'(bus.dmem_req), 32'd1);
    n_wait = 0;
    seen   = 1'b0;
    for (int i = 0; i < 400; i++) begin
      drive(1'b1, 6'd25, 5'd0, 1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0);
      n_wait++;
      if (bus.retire) begin
        seen = 1'b1;
        break;
      end
    end
    chk("to_seen",   32'(seen), 32'd1);
    chk("to_len",    32'(n_wait), 32'd255);
    bubble();
    chk("to_mem_err", 32'(bus.mem_err), 32'd1);
    chk("to_run",     32'(bus.pc_sel), 32'd0);
    chk("to_instret", bus.instret_cnt, 32'd0);
    drive(1'b0, 6'd0, 5'd0, 1'b0, 1'b0, 5'd0, 5'd0, 1'b1, 1'b0);
    chk("stray_rdy_retire", 32'(bus.retire), 32'd0);
    chk("stray_rdy_req",    32'(bus.dmem_req), 32'd0);

    // Counter clear beats a coincident retire
    drive(1'b1, 6'd1, 5'd3, 1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0);
    drive(1'b1, 6'd1, 5'd3, 1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 1'b1);
    chk("clr_retire", 32'(bus.retire), 32'd1);
    bubble();
    chk("clr_instret", bus.instret_cnt, 32'd0);
    chk("clr_cycle",   bus.cycle_cnt, 32'd0);

    // cycle_cnt wrap
    @(negedge clk);
    force dut.u_perf.cycle_q = 32'hFFFF_FFFF;
    #1;
    release dut.u_perf.cycle_q;
    chk("wrap_pre",  bus.cycle_cnt, 32'hFFFF_FFFF);
    bubble();
    chk("wrap_post", bus.cycle_cnt, 32'd0);

    // Reset asserted mid-MEM drops the request without retiring
    drive(1'b1, 6'd12, 5'd4, 1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0);
    drive(1'b1, 6'd12, 5'd4, 1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0);
    chk("mid_mem_req", 32'(bus.dmem_req), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_req",     32'(bus.dmem_req), 32'd0);
    chk("arst_retire",  32'(bus.retire), 32'd0);
    chk("arst_pc_sel",  32'(bus.pc_sel), 32'd2);
    chk("arst_instret", bus.instret_cnt, 32'd0);
    chk("arst_mem_err", 32'(bus.mem_err), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
